// File: rtl/rf_debug_reader.sv
// Debug-side register-file dumper: freezes writes, reads each register through one port and streams it out.
// Define RF_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module rf_debug_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_req,
    output logic              enable_debug,
    output logic [4:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_index,
    output logic              out_last,
    output logic              dbg_busy,
    output logic              dbg_done
);

`ifdef RF_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FREEZE = 3'd1,
        FETCH  = 3'd2,
        SEND   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FREEZE = 3'd1,
        FETCH  = 3'd2,
        SEND   = 3'd3,
        DONE   = 3'd5
    } state_t;
`endif

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [4:0]          rd_addr_q, rd_addr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [4:0]          index_q, index_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef RF_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    logic handshake_s;
    assign handshake_s = valid_q && out_ready;

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        index_d   = index_q;
        last_d    = last_q;
        done_d    = 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    state_d   = FREEZE;
                    idx_d     = 5'd0;
                    rd_addr_d = 5'd0;
`ifdef RF_DUMP_CHECKSUM_EN
                    csum_d    = {DATA_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            // One idle cycle with writes frozen lets an in-flight write retire.
            FREEZE: begin
                state_d   = FETCH;
                rd_addr_d = idx_q;
            end
            FETCH: begin
                state_d = SEND;
                data_d  = rf_rd_data;
                index_d = idx_q;
                valid_d = 1'b1;
`ifdef RF_DUMP_CHECKSUM_EN
                last_d  = 1'b0;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
            end
            SEND: begin
                if (handshake_s) begin
`ifdef RF_DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ data_q;
`endif
                    if (idx_q < LAST_IDX) begin
                        idx_d     = idx_q + 5'd1;
                        rd_addr_d = idx_q + 5'd1;
                        valid_d   = 1'b0;
                        state_d   = FETCH;
                    end else begin
`ifdef RF_DUMP_CHECKSUM_EN
                        // Valid stays high: the checksum word follows with no fetch gap.
                        state_d = CSUM;
                        data_d  = csum_q ^ data_q;
                        index_d = 5'd0;
                        last_d  = 1'b1;
`else
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    state_d = SEND;
                end
            end
`ifdef RF_DUMP_CHECKSUM_EN
            CSUM: begin
                if (handshake_s) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = CSUM;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 5'd0;
            rd_addr_q <= 5'd0;
            valid_q   <= 1'b0;
            data_q    <= {DATA_W{1'b0}};
            index_q   <= 5'd0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_q    <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            index_q   <= index_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign enable_debug = busy_q;
    assign dbg_busy     = busy_q;
    assign dbg_done     = done_q;
    assign rf_rd_addr   = rd_addr_q;
    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_index    = index_q;
    assign out_last     = last_q;

endmodule

// File: tb/tb_rf_debug_reader.sv
// Self-checking bench for rf_debug_reader: word-level reference model plus directed and random dumps.
module tb_rf_debug_reader;
    localparam int NR = 32;
`ifdef RF_DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_req = 1'b0;
    logic        out_ready = 1'b1;
    logic        enable_debug, out_valid, out_last, dbg_busy, dbg_done;
    logic [4:0]  rf_rd_addr, out_index;
    logic [31:0] rf_rd_data, out_data;

    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] regs [0:NR-1];

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    rf_debug_reader #(.NUM_REGS(NR), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .dbg_req(dbg_req), .enable_debug(enable_debug),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
    );

    // Register file: combinational read, negedge write blocked while frozen.
    assign rf_rd_data = regs[rf_rd_addr];
    always @(negedge clk) begin
        if (wr_en && !enable_debug) regs[wr_addr] <= wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of words to emit, and when each one is visible.
    typedef struct packed { logic [31:0] d; logic [4:0] i; logic l; } word_t;
    word_t m_words[$];
    bit    m_active = 1'b0, m_valid = 1'b0, m_done = 1'b0;
    int    m_pos = 0, m_gap = 0;

    initial forever begin
        logic [31:0] x;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_valid = 1'b0; m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0; m_active = 1'b0;
        end else if (!m_active) begin
            if (dbg_req) begin
                m_words.delete();
                x = 32'd0;
                for (int i = 0; i < NR; i++) begin
                    m_words.push_back(word_t'{regs[i], 5'(i), (i == NR - 1) && !CK});
                    x = x ^ regs[i];
                end
                if (CK) m_words.push_back(word_t'{x, 5'd0, 1'b1});
                m_active = 1'b1; m_valid = 1'b0; m_pos = 0; m_gap = 2;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_pos++;
                if (m_pos == m_words.size()) begin
                    m_valid = 1'b0; m_done = 1'b1;
                end else if (!(CK && m_pos == NR)) begin
                    m_valid = 1'b0; m_gap = 1;
                end
            end
        end else begin
            m_gap--;
            if (m_gap == 0) m_valid = 1'b1;
        end
    end

    logic [31:0] acc_d[$];
    logic [4:0]  acc_i[$];
    logic        acc_l[$];
    word_t       cw;

    // Compare process: DUT outputs against the model on every cycle after reset.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("enable_debug", 32'(enable_debug), 32'(m_active));
            check("dbg_busy", 32'(dbg_busy), 32'(m_active));
            check("dbg_done", 32'(dbg_done), 32'(m_done));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                cw = m_words[m_pos];
                check("out_data", out_data, cw.d);
                check("out_index", 32'(out_index), 32'(cw.i));
                check("out_last", 32'(out_last), 32'(cw.l));
            end
            if (out_valid === 1'b1 && out_ready) begin
                acc_d.push_back(out_data);
                acc_i.push_back(out_index);
                acc_l.push_back(out_last);
            end
            if (dbg_done === 1'b1) n_done++;
        end
    end

    task automatic clear_acc();
        acc_d.delete(); acc_i.delete(); acc_l.delete();
    endtask

    task automatic preload(input int mode);
        for (int i = 0; i < NR; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1;
            wr_addr = 5'(i);
            case (mode)
                0: wr_data = 32'h1000_0000 + 32'(i);
                1: wr_data = (i == 1) ? 32'hA5A5_A5A5 : ((i == 2) ? 32'h0F0F_0F0F : 32'd0);
                default: wr_data = $urandom;
            endcase
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic start_dump();
        @(posedge clk); #1; dbg_req = 1'b1;
        @(posedge clk); #1; dbg_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (dbg_done !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        check(name, 32'(n < 1000), 32'd1);
    endtask

    task automatic wait_word(input logic [4:0] idx, input string name);
        int n = 0;
        while (!(out_valid === 1'b1 && out_index === idx) && n < 1000) begin @(posedge clk); #1; n++; end
        check(name, 32'(n < 1000), 32'd1);
    endtask

    initial begin
        int d0, bad, n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_en", 32'(enable_debug), 32'd0);
        check("rst_busy", 32'(dbg_busy), 32'd0);
        check("rst_done", 32'(dbg_done), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_addr", 32'(rf_rd_addr), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Basic in-order dump
        preload(0);
        clear_acc();
        d0 = n_done;
        start_dump();
        wait_done("t1_done_timeout");
        @(posedge clk); #1;
        check("t1_en_drop", 32'(enable_debug), 32'd0);
        check("t1_done_pulse", 32'(n_done - d0), 32'd1);
        check("t1_count", 32'(acc_d.size()), 32'(NR + int'(CK)));
        bad = 0;
        for (int i = 0; i < NR && i < acc_d.size(); i++)
            if (acc_d[i] !== 32'h1000_0000 + 32'(i) || acc_i[i] !== 5'(i)) bad++;
        check("t1_order", 32'(bad), 32'd0);
        if (acc_d.size() >= NR) begin
            check("t1_w31", acc_d[31], 32'h1000_001F);
            check("t1_w31_last", 32'(acc_l[31]), 32'(!CK));
        end

        // Backpressure, frozen write, ignored dbg_req
        clear_acc();
        start_dump();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        repeat (3) begin @(posedge clk); #1; end
        wr_en = 1'b0;
        wait_word(5'd3, "t2_w3_timeout");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t2_bp_valid", 32'(out_valid), 32'd1);
            check("t2_bp_data", out_data, 32'h1000_0003);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_word(5'd7, "t2_w7_timeout");
        dbg_req = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        dbg_req = 1'b0;
        wait_done("t2_done_timeout");
        repeat (3) begin @(posedge clk); #1; end
        check("t2_no_requeue", 32'(dbg_busy), 32'd0);
        check("t2_count", 32'(acc_d.size()), 32'(NR + int'(CK)));
        if (acc_d.size() > 5) begin
            check("t2_w4", acc_d[4], 32'h1000_0004);
            check("t2_w5_frozen", acc_d[5], 32'h1000_0005);
        end

        // Reset mid-dump, then restart from index 0
        start_dump();
        wait_word(5'd10, "t3_w10_timeout");
        rst = 1'b1;
        @(posedge clk); #1;
        check("t3_rst_valid", 32'(out_valid), 32'd0);
        check("t3_rst_en", 32'(enable_debug), 32'd0);
        check("t3_rst_busy", 32'(dbg_busy), 32'd0);
        rst = 1'b0;
        clear_acc();
        start_dump();
        wait_done("t3_done_timeout");
        check("t3_count", 32'(acc_d.size()), 32'(NR + int'(CK)));
        if (acc_d.size() > 5) begin
            check("t3_first_idx", 32'(acc_i[0]), 32'd0);
            check("t3_reread_w5", acc_d[5], 32'h1000_0005);
        end

`ifdef RF_DUMP_CHECKSUM_EN
        preload(1);
        clear_acc();
        start_dump();
        wait_done("t4_done_timeout");
        check("t4_count", 32'(acc_d.size()), 32'(NR + 1));
        if (acc_d.size() == NR + 1) begin
            check("t4_csum", acc_d[NR], 32'hAAAA_AAAA);
            check("t4_csum_last", 32'(acc_l[NR]), 32'd1);
            check("t4_csum_idx", 32'(acc_i[NR]), 32'd0);
            check("t4_w31_last", 32'(acc_l[NR-1]), 32'd0);
        end
`endif

        // Random traffic: writes, backpressure and request noise
        preload(2);
        d0 = n_done;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            dbg_req   = ($urandom_range(0, 15) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 5'($urandom_range(0, NR - 1));
            wr_data   = $urandom;
        end
        dbg_req = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
        n = 0;
        while (dbg_busy !== 1'b0 && n < 1000) begin @(posedge clk); #1; n++; end
        check("rand_idle_timeout", 32'(n < 1000), 32'd1);
        @(posedge clk); #1;
        check("rand_dumps", 32'((n_done - d0) >= 3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
